// File: rtl/gray_sweep_ctrl.sv
// Gray-code sweep controller.
// Walks a WIDTH-bit binary counter up or down through its full range and
// offers each code (binary and Gray) to a consumer with a valid/ready
// handshake. Supports single or continuous sweeps, abort via stop, and
// counts wraps in continuous mode.
module gray_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             mode,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             busy,
    output logic             done,
    output logic [7:0]       wrap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [7:0]       wrap_q, wrap_d;

    // Start and end codes depend only on the direction latched at start.
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    assign start_val = dir_q ? ALL_ONES : '0;
    assign end_val   = dir_q ? '0 : ALL_ONES;

    // Next-state and next-datapath computation for the sweep FSM.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        bin_d   = bin_q;
        wrap_d  = wrap_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    dir_d   = dir;
                    mode_d  = mode;
                    bin_d   = dir ? ALL_ONES : '0;
                    wrap_d  = '0;
                end
            end
            S_RUN: begin
                // stop wins over any handshake or end-code action this cycle
                if (stop) begin
                    state_d = S_DONE;
                end else if (ready) begin
                    if (bin_q == end_val) begin
                        if (mode_q) begin
                            bin_d  = start_val;
                            wrap_d = wrap_q + 8'd1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bin_d = dir_q ? (bin_q - ONE) : (bin_q + ONE);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            bin_q   <= '0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            bin_q   <= bin_d;
            wrap_q  <= wrap_d;
        end
    end

    // Outputs are pure decodes of registered state.
    assign valid    = (state_q == S_RUN);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign bin_out  = bin_q;
    assign gray_out = bin_q ^ (bin_q >> 1);
    assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Testbench for gray_sweep_ctrl: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural model.
module tb_gray_sweep_ctrl;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         dir = 1'b0;
    logic         mode = 1'b0;
    logic         ready = 1'b0;
    logic         valid;
    logic [W-1:0] bin_out;
    logic [W-1:0] gray_out;
    logic         busy;
    logic         done;
    logic [7:0]   wrap_cnt;

    gray_sweep_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .mode     (mode),
        .ready    (ready),
        .valid    (valid),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .busy     (busy),
        .done     (done),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        int g = 0;
        for (int i = 0; i < W; i++) begin
            int lo = (b >> i) & 1;
            int hi = (i + 1 < W) ? ((b >> (i + 1)) & 1) : 0;
            g = g | ((lo ^ hi) << i);
        end
        return g;
    endfunction

    // Behavioural model: phase 0 = idle, 1 = sweeping, 2 = finishing
    int           m_phase = 0;
    int           m_dir = 0;
    int           m_mode = 0;
    int           m_bin = 0;
    int           m_wrap = 0;
    logic [W-1:0] seen_gray = '0;
    logic [W-1:0] prev_gray = '0;
    bit           have_prev = 0;

    initial begin
        logic s_i, st_i, d_i, md_i, r_i, rs_i;
        int   end_code;
        forever begin
            @(posedge clk);
            s_i = start; st_i = stop; d_i = dir; md_i = mode; r_i = ready; rs_i = rst_n;
            #1;
            if (!rs_i) begin
                m_phase = 0; m_bin = 0; m_wrap = 0; have_prev = 0;
            end else begin
                case (m_phase)
                    0: if (s_i) begin
                        m_phase = 1; m_dir = d_i; m_mode = md_i;
                        m_bin = d_i ? N - 1 : 0; m_wrap = 0; have_prev = 0;
                    end
                    1: if (st_i) begin
                        m_phase = 2;
                    end else if (r_i) begin
                        if (have_prev) chk("gray_one_bit_step", $countones(prev_gray ^ seen_gray), 1);
                        prev_gray = seen_gray;
                        have_prev = 1;
                        end_code = m_dir ? 0 : N - 1;
                        if (m_bin == end_code) begin
                            if (m_mode) begin
                                m_bin  = m_dir ? N - 1 : 0;
                                m_wrap = (m_wrap + 1) % 256;
                            end else begin
                                m_phase = 2;
                            end
                        end else begin
                            m_bin = (m_bin + (m_dir ? N - 1 : 1)) % N;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
            chk("valid", valid, m_phase == 1);
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_phase == 2);
            chk("bin_out", bin_out, m_bin);
            chk("gray_out", gray_out, gray_of(m_bin));
            chk("wrap_cnt", wrap_cnt, m_wrap);
            seen_gray = gray_out;
        end
    end

    // Caller sits at a negedge; waits (bounded) until bin_out shows target.
    task automatic wait_bin(input int target);
        int k = 0;
        while (bin_out !== target && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wait_bin", bin_out, target);
    endtask

    int gtab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    initial begin
        int cnt, last, pulses, k;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bin", bin_out, 0);
        chk("rst_gray", gray_out, 0);
        chk("rst_wrap", wrap_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // stop in idle is ignored
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("idle_stop_busy", busy, 0);

        // Up single sweep with a stray start pulse mid-run
        dir = 1'b0; mode = 1'b0; ready = 1'b1; start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
            if (c <= 16) begin
                chk("up_gray_lit", gray_out, gtab[c-1]);
                chk("up_valid_lit", valid, 1);
            end else if (c == 17) begin
                chk("up_done_lit", done, 1);
                chk("up_valid_end", valid, 0);
            end else begin
                chk("up_busy_after", busy, 0);
                chk("up_bin_hold", bin_out, 15);
                chk("up_gray_hold", gray_out, 8);
            end
        end

        // Down single sweep
        dir = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("dn_first_bin", bin_out, 15);
        chk("dn_first_gray", gray_out, 8);
        cnt = 0; last = -1; k = 0;
        while (valid && k < 50) begin
            cnt++; last = bin_out;
            @(negedge clk);
            k++;
        end
        chk("dn_count", cnt, 16);
        chk("dn_last_bin", last, 0);
        chk("dn_done", done, 1);
        @(negedge clk);
        chk("dn_done_once", done, 0);

        // Backpressure at bin 0101
        dir = 1'b0; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_bin(5);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_gray_hold", gray_out, 7);
            chk("bp_valid_hold", valid, 1);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("bp_next_bin", bin_out, 6);
        chk("bp_next_gray", gray_out, 5);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("bp_abort_done", done, 1);
        @(negedge clk);

        // Continuous up: wrap then stop
        mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_bin(15);
        chk("cont_wrap0", wrap_cnt, 0);
        @(negedge clk);
        chk("cont_wrap_bin", bin_out, 0);
        chk("cont_wrap1", wrap_cnt, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("cont_stop_done", done, 1);
        chk("cont_stop_wrap", wrap_cnt, 1);
        chk("cont_stop_bin", bin_out, 0);
        @(negedge clk);
        chk("cont_idle_busy", busy, 0);
        chk("cont_idle_wrap", wrap_cnt, 1);

        // stop coincident with end code in continuous mode
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_bin(15);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("se_done", done, 1);
        chk("se_no_wrap", wrap_cnt, 0);
        chk("se_bin", bin_out, 15);
        pulses = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("se_one_pulse", pulses, 1);

        // Async reset mid-sweep
        mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_bin(6);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_bin", bin_out, 0);
        chk("ar_gray", gray_out, 0);
        chk("ar_wrap", wrap_cnt, 0);
        @(negedge clk);
        chk("ar_no_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_idle", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ar_fresh_bin", bin_out, 0);
        chk("ar_fresh_valid", valid, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom % 8) == 0;
            stop  = ($urandom % 24) == 0;
            dir   = $urandom % 2;
            mode  = $urandom % 2;
            ready = ($urandom % 4) != 0;
            rst_n = ($urandom % 300) != 0;
        end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
